line_ram_controller: RTL

- Main-memory model/controller directly downstream of the data-cache top.
- Services line-granular (256-bit) refill reads and write-backs issued by the cache controller.
- Responds after a fixed, parameterised latency with a one-cycle response pulse.
- Holds a DEPTH-line backing store and keeps read/write transaction counters for performance checks.

---
 rtl/line_ram_controller_if.sv | 37 +++
 rtl/line_ram_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/line_ram_controller_if.sv
// Line-granular request/response bundle between the data cache (master)
// and the line RAM controller (slave).
interface line_ram_controller_if;
    logic         enable_cache_to_ram;
    logic         write_cache_to_ram;
    logic [31:0]  address_cache_to_ram;
    logic [255:0] data_cache_to_ram_i;
    logic         response_ram_to_cache;
    logic [255:0] data_ram_to_cache_o;
    logic         busy;
    logic [31:0]  read_count;
    logic [31:0]  write_count;

    modport master (
        output enable_cache_to_ram,
        output write_cache_to_ram,
        output address_cache_to_ram,
        output data_cache_to_ram_i,
        input  response_ram_to_cache,
        input  data_ram_to_cache_o,
        input  busy,
        input  read_count,
        input  write_count
    );

    modport slave (
        input  enable_cache_to_ram,
        input  write_cache_to_ram,
        input  address_cache_to_ram,
        input  data_cache_to_ram_i,
        output response_ram_to_cache,
        output data_ram_to_cache_o,
        output busy,
        output read_count,
        output write_count
    );
endinterface

// File: rtl/line_ram_controller.sv
// Main-memory model behind the data cache: 256-bit line store with a fixed
// request-to-response latency, a one-cycle response pulse and R/W counters.
//
// state | meaning
// IDLE  | waiting for enable; request latched on the accepting edge
// BUSY  | latency down-counter running; inputs ignored
// RESP  | response pulse cycle; access committed on entry
module line_ram_controller #(
    parameter int LINE_ADDR_W = 10,
    parameter int LATENCY     = 4
) (
    input logic                 clk,
    input logic                 rst,
    line_ram_controller_if.slave bus
);

    localparam int         DEPTH  = 1 << LINE_ADDR_W;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [LINE_ADDR_W-1:0] idx_q, idx_d;
    logic [255:0]           wdata_q, wdata_d;
    logic                   resp_q, resp_d;
    logic [255:0]           rdata_q, rdata_d;
    logic [31:0]            rd_cnt_q, rd_cnt_d;
    logic [31:0]            wr_cnt_q, wr_cnt_d;

    logic [255:0]           mem_q [0:DEPTH-1];

    logic                   commit;
    logic                   commit_wr;
    logic [LINE_ADDR_W-1:0] commit_idx;
    logic [255:0]           commit_data;
    logic [LINE_ADDR_W-1:0] req_idx;

    logic                   unused_addr;
    assign unused_addr = ^{bus.address_cache_to_ram[31:LINE_ADDR_W+5],
                           bus.address_cache_to_ram[4:0]};

    assign req_idx = bus.address_cache_to_ram[LINE_ADDR_W+4:5];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        resp_d      = 1'b0;
        rdata_d     = rdata_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        commit      = 1'b0;
        commit_wr   = wr_q;
        commit_idx  = idx_q;
        commit_data = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.enable_cache_to_ram) begin
                    wr_d    = bus.write_cache_to_ram;
                    idx_d   = req_idx;
                    wdata_d = bus.data_cache_to_ram_i;
                    // With unit latency the access commits on the accepting edge itself.
                    if (LATENCY == 1) begin
                        state_d     = S_RESP;
                        commit      = 1'b1;
                        commit_wr   = bus.write_cache_to_ram;
                        commit_idx  = req_idx;
                        commit_data = bus.data_cache_to_ram_i;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            resp_d = 1'b1;
            if (commit_wr) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
                rdata_d  = mem_q[commit_idx];
            end
        end
    end

    // Store has no reset; gating on rst keeps a held-in-reset request from committing.
    always_ff @(posedge clk) begin
        if (rst && commit && commit_wr) begin
            mem_q[commit_idx] <= commit_data;
        end
    end

    assign bus.response_ram_to_cache = resp_q;
    assign bus.data_ram_to_cache_o   = rdata_q;
    assign bus.busy                  = (state_q != S_IDLE);
    assign bus.read_count            = rd_cnt_q;
    assign bus.write_count           = wr_cnt_q;

endmodule
